// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: load opcodes, FSM states, timeout and
// the latched request payload, plus lane/alignment helpers.
package processor_defines;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned CTRL_W       = 3;
    localparam int unsigned BE_W         = XLEN / 8;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned LOAD_TIMEOUT = 15;

    typedef enum logic [CTRL_W-1:0] {
        LD_NOP = 3'd0,
        LB     = 3'd1,
        LH     = 3'd2,
        LW     = 3'd3,
        LBU    = 3'd4,
        LHU    = 3'd5
    } load_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } load_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   ea;
        load_ctrl_e        ctrl;
        logic [REG_AW-1:0] rd;
    } load_req_t;

    // Unused encodings (6, 7) behave like LD_NOP.
    function automatic logic is_load(input load_ctrl_e ctrl);
        logic hit;
        case (ctrl)
            LB, LH, LW, LBU, LHU: hit = 1'b1;
            default:              hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_misaligned(input load_ctrl_e ctrl, input logic [1:0] ea_lo);
        logic bad;
        case (ctrl)
            LH, LHU: bad = ea_lo[0];
            LW:      bad = (ea_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [BE_W-1:0] byte_enable(input load_ctrl_e ctrl, input logic [1:0] ea_lo);
        logic [BE_W-1:0] be;
        case (ctrl)
            LB, LBU: be = BE_W'(4'b0001 << ea_lo);
            LH, LHU: be = ea_lo[1] ? 4'b1100 : 4'b0011;
            LW:      be = 4'b1111;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_unit_align.sv
// Combinational byte/halfword extraction and sign/zero extension of a
// memory word according to the load opcode and the low address bits.
module load_align
    import processor_defines::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      ea_lo_i,
    input  load_ctrl_e      ctrl_i,
    output logic [XLEN-1:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (ea_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = ea_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (ctrl_i)
            LB:      value_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     value_o = {24'd0, byte_sel};
            LH:      value_o = {{16{half_sel[15]}}, half_sel};
            LHU:     value_o = {16'd0, half_sel};
            LW:      value_o = word_i;
            default: value_o = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load unit: computes the effective address, issues a word read,
// waits for the memory response (with timeout) and writes the result back.
module load_unit
    import processor_defines::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [CTRL_W-1:0] load_control,
    input  logic [XLEN-1:0]   mem_read_data,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              ignore_curr_inst,
    output logic              mem_rw_mode,
    output logic [XLEN-1:0]   mem_addr,
    output logic [BE_W-1:0]   mem_byte_en,
    output logic              rd_write_en,
    output logic [REG_AW-1:0] rd_write_addr,
    output logic [XLEN-1:0]   rd_write_data,
    output logic              load_misaligned,
    output logic              load_fault
);

    load_state_e      state_q, state_d;
    load_req_t        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [XLEN-1:0]  data_q, data_d;
    logic             misaligned_q, misaligned_d;
    logic             fault_q, fault_d;

    load_ctrl_e       ctrl_in;
    logic [XLEN-1:0]  ea;
    logic [XLEN-1:0]  aligned;
    logic             new_load, new_misaligned, timeout;

    assign ctrl_in        = load_ctrl_e'(load_control);
    assign ea             = rs1_val + imm;
    assign new_load       = is_load(ctrl_in);
    assign new_misaligned = is_misaligned(ctrl_in, ea[1:0]);
    assign cnt_inc        = CNT_W'(cnt_q + 1'b1);
    assign timeout        = (cnt_inc == CNT_W'(LOAD_TIMEOUT));

    load_align u_align (
        .word_i  (mem_read_data),
        .ea_lo_i (req_q.ea[1:0]),
        .ctrl_i  (req_q.ctrl),
        .value_o (aligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (new_load && !new_misaligned) state_d = WAIT;
            // A response in the timeout cycle still completes the load.
            WAIT: begin
                if (mem_ready) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_pc         = 1'b0;
        ignore_curr_inst = 1'b0;
        rd_write_en      = 1'b0;
        mem_addr         = '0;
        mem_byte_en      = '0;
        case (state_q)
            IDLE: stall_pc = new_load && !i_rst;
            WAIT: begin
                stall_pc    = 1'b1;
                mem_addr    = {req_q.ea[XLEN-1:2], 2'b00};
                mem_byte_en = byte_enable(req_q.ctrl, req_q.ea[1:0]);
            end
            DONE: begin
                ignore_curr_inst = 1'b1;
                rd_write_en      = (req_q.rd != '0);
            end
            default: ;
        endcase
    end

    // Request latch, wait counter, response data and error pulses.
    always_comb begin
        req_d        = req_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        misaligned_d = 1'b0;
        fault_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_load) begin
                    if (new_misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        req_d.ea   = ea;
                        req_d.ctrl = ctrl_in;
                        req_d.rd   = rd_addr;
                        cnt_d      = '0;
                    end
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    data_d = aligned;
                    cnt_d  = '0;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            misaligned_q <= misaligned_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_rw_mode     = 1'b1;
    assign rd_write_addr   = req_q.rd;
    assign rd_write_data   = data_q;
    assign load_misaligned = misaligned_q;
    assign load_fault      = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: inputs change on the falling edge and outputs
// are sampled 1ns later, so each step observes one full DUT cycle.
module tb_load_unit;
    import processor_defines::*;

    logic              i_clk;
    logic              i_rst;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd_addr;
    logic [CTRL_W-1:0] load_control;
    logic [XLEN-1:0]   mem_read_data;
    logic              mem_ready;
    logic              stall_pc;
    logic              ignore_curr_inst;
    logic              mem_rw_mode;
    logic [XLEN-1:0]   mem_addr;
    logic [BE_W-1:0]   mem_byte_en;
    logic              rd_write_en;
    logic [REG_AW-1:0] rd_write_addr;
    logic [XLEN-1:0]   rd_write_data;
    logic              load_misaligned;
    logic              load_fault;

    int checks = 0;
    int errors = 0;

    load_unit dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .rs1_val          (rs1_val),
        .imm              (imm),
        .rd_addr          (rd_addr),
        .load_control     (load_control),
        .mem_read_data    (mem_read_data),
        .mem_ready        (mem_ready),
        .stall_pc         (stall_pc),
        .ignore_curr_inst (ignore_curr_inst),
        .mem_rw_mode      (mem_rw_mode),
        .mem_addr         (mem_addr),
        .mem_byte_en      (mem_byte_en),
        .rd_write_en      (rd_write_en),
        .rd_write_addr    (rd_write_addr),
        .rd_write_data    (rd_write_data),
        .load_misaligned  (load_misaligned),
        .load_fault       (load_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    task automatic issue(input logic [2:0] c, input logic [31:0] r, input logic [31:0] i,
                         input logic [4:0] rd);
        load_control = c;
        rs1_val      = r;
        imm          = i;
        rd_addr      = rd;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall_pc), 32'd0);
        chk({tag, "_ign"},   32'(ignore_curr_inst), 32'd0);
        chk({tag, "_be"},    32'(mem_byte_en), 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_wen"},   32'(rd_write_en), 32'd0);
        chk({tag, "_rw"},    32'(mem_rw_mode), 32'd1);
    endtask

    initial begin
        i_rst = 1'b1;
        issue(LD_NOP, 32'd0, 32'd0, 5'd0);
        mem_read_data = 32'd0;
        mem_ready     = 1'b0;
        #1;
        idle_outputs("rst");
        chk("rst_mis",   32'(load_misaligned), 32'd0);
        chk("rst_fault", 32'(load_fault), 32'd0);
        chk("rst_wa",    32'(rd_write_addr), 32'd0);
        chk("rst_wd",    rd_write_data, 32'd0);
        nxt(); nxt();
        i_rst = 1'b0;

        // LB at 0x1003, response on third WAIT cycle
        nxt(); issue(LB, 32'h1000, 32'd3, 5'd5); #1;
        chk("lb_stall0", 32'(stall_pc), 32'd1);
        chk("lb_be_idle", 32'(mem_byte_en), 32'd0);
        nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
        chk("lb_stall1", 32'(stall_pc), 32'd1);
        chk("lb_addr", mem_addr, 32'h0000_1000);
        chk("lb_be", 32'(mem_byte_en), 32'b1000);
        nxt(); #1;
        chk("lb_stall2", 32'(stall_pc), 32'd1);
        nxt(); mem_ready = 1'b1; mem_read_data = 32'h80FF_0000; #1;
        chk("lb_stall3", 32'(stall_pc), 32'd1);
        nxt(); mem_ready = 1'b0; mem_read_data = 32'd0; #1;
        chk("lb_stall4", 32'(stall_pc), 32'd0);
        chk("lb_ign", 32'(ignore_curr_inst), 32'd1);
        chk("lb_wen", 32'(rd_write_en), 32'd1);
        chk("lb_wa", 32'(rd_write_addr), 32'd5);
        chk("lb_wd", rd_write_data, 32'hFFFF_FF80);
        chk("lb_addr_done", mem_addr, 32'd0);
        nxt(); #1;
        idle_outputs("lb_post");

        // LHU at 0x2002; a competing LW during WAIT/DONE must be ignored
        nxt(); issue(LHU, 32'h2000, 32'd2, 5'd7); #1;
        chk("lhu_stall0", 32'(stall_pc), 32'd1);
        nxt(); issue(LW, 32'h9000, 32'd0, 5'd3); #1;
        chk("lhu_be", 32'(mem_byte_en), 32'b1100);
        chk("lhu_addr", mem_addr, 32'h0000_2000);
        nxt(); mem_ready = 1'b1; mem_read_data = 32'h9ABC_1234; #1;
        chk("lhu_addr_hold", mem_addr, 32'h0000_2000);
        nxt(); mem_ready = 1'b0; #1;
        chk("lhu_wd", rd_write_data, 32'h0000_9ABC);
        chk("lhu_wa", 32'(rd_write_addr), 32'd7);
        chk("lhu_wen", 32'(rd_write_en), 32'd1);
        chk("lhu_done_stall", 32'(stall_pc), 32'd0);
        nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
        idle_outputs("lhu_post");

        // LH sign-extension on the same word, low half
        nxt(); issue(LH, 32'h2000, 32'd0, 5'd8); #1;
        nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); mem_ready = 1'b1;
        mem_read_data = 32'h1234_9ABC; #1;
        chk("lh_be", 32'(mem_byte_en), 32'b0011);
        nxt(); mem_ready = 1'b0; #1;
        chk("lh_wd", rd_write_data, 32'hFFFF_9ABC);
        chk("lh_wa", 32'(rd_write_addr), 32'd8);

        // Misaligned LW at 0x3001
        nxt(); issue(LW, 32'h3000, 32'd1, 5'd9); #1;
        chk("mis_stall0", 32'(stall_pc), 32'd1);
        nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
        chk("mis_pulse", 32'(load_misaligned), 32'd1);
        idle_outputs("mis_1");
        nxt(); #1;
        chk("mis_clear", 32'(load_misaligned), 32'd0);
        idle_outputs("mis_2");

        // LW at 0x4000 with no response: fault after 15 WAIT cycles
        nxt(); issue(LW, 32'h4000, 32'd0, 5'd10); #1;
        for (int k = 0; k < 15; k++) begin
            nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
            chk("to_stall", 32'(stall_pc), 32'd1);
            chk("to_nofault", 32'(load_fault), 32'd0);
        end
        nxt(); #1;
        chk("to_fault", 32'(load_fault), 32'd1);
        idle_outputs("to_idle");
        nxt(); #1;
        chk("to_fault_clr", 32'(load_fault), 32'd0);

        // Response in the final WAIT cycle beats the timeout
        nxt(); issue(LW, 32'h5000, 32'd0, 5'd11); #1;
        for (int k = 0; k < 14; k++) begin
            nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
        end
        nxt(); mem_ready = 1'b1; mem_read_data = 32'h1234_5678; #1;
        chk("race_stall", 32'(stall_pc), 32'd1);
        nxt(); mem_ready = 1'b0; #1;
        chk("race_nofault", 32'(load_fault), 32'd0);
        chk("race_wen", 32'(rd_write_en), 32'd1);
        chk("race_wd", rd_write_data, 32'h1234_5678);
        nxt(); #1;
        chk("race_nofault2", 32'(load_fault), 32'd0);

        // Asynchronous reset in the middle of WAIT
        nxt(); issue(LW, 32'h6000, 32'd0, 5'd12); #1;
        nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
        chk("rw_be", 32'(mem_byte_en), 32'b1111);
        #2 i_rst = 1'b1;
        #1;
        idle_outputs("rw_rst");
        chk("rw_wa", 32'(rd_write_addr), 32'd0);
        chk("rw_wd", rd_write_data, 32'd0);
        nxt(); i_rst = 1'b0; mem_ready = 1'b1; mem_read_data = 32'hCAFE_F00D; #1;
        idle_outputs("rw_rel");
        for (int k = 0; k < 3; k++) begin
            nxt(); mem_ready = 1'b0; #1;
            chk("rw_nowen", 32'(rd_write_en), 32'd0);
            chk("rw_nofault", 32'(load_fault), 32'd0);
            chk("rw_nostall", 32'(stall_pc), 32'd0);
        end

        // LW to x0: DONE happens but no register write
        nxt(); issue(LW, 32'h7000, 32'd0, 5'd0); #1;
        nxt(); issue(LD_NOP, 32'd0, 32'd0, 5'd0); #1;
        nxt(); mem_ready = 1'b1; mem_read_data = 32'hDEAD_BEEF; #1;
        nxt(); mem_ready = 1'b0; #1;
        chk("x0_wen", 32'(rd_write_en), 32'd0);
        chk("x0_ign", 32'(ignore_curr_inst), 32'd1);
        chk("x0_stall", 32'(stall_pc), 32'd0);
        chk("x0_wd", rd_write_data, 32'hDEAD_BEEF);
        nxt(); #1;
        chk("x0_ign_clr", 32'(ignore_curr_inst), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named i_clk and i_rst.
REQ-002 i_clk  input  1  rising-edge clock.
REQ-003 i_rst  input  1  asynchronous active-high reset.
REQ-004 rs1_val  input  32  base register value.
REQ-005 imm  input  32  sign-extended load offset.
REQ-006 rd_addr  input  5  destination register index.
REQ-007 load_control  input  3  load opcode: LD_NOP, LB, LH, LW, LBU or LHU (package encodings).
REQ-008 mem_read_data  input  32  word read from memory; valid when mem_ready=1.
REQ-009 mem_ready  input  1  memory read-response strobe.
REQ-010 stall_pc  output  1  holds the PC while a load is in flight.
REQ-011 ignore_curr_inst  output  1  squashes the instruction fetched during the stall.
REQ-012 mem_rw_mode  output  1  1=read/idle, 0=write; the unit SHALL never drive 0.
REQ-013 mem_addr  output  32  word-aligned read address {ea[31:2],2'b00}.
REQ-014 mem_byte_en  output  4  byte lanes requested.
REQ-015 rd_write_en, rd_write_addr[4:0], rd_write_data[31:0]  output  register writeback.
REQ-016 load_misaligned, load_fault  output  1 each  one-cycle error pulses.

Function
REQ-017 ea = rs1_val + imm, modulo 2^32; carry is discarded.
REQ-018 FSM states: IDLE, WAIT, DONE.
REQ-019 IDLE: a non-LD_NOP load_control SHALL assert stall_pc combinationally in the same cycle.
REQ-020 IDLE, aligned load: latch ea, control and rd_addr, clear the wait counter, go to WAIT next edge.
REQ-021 Misaligned load = LH/LHU with ea[0]=1, or LW with ea[1:0]!=0.
REQ-022 IDLE, misaligned load: no transition to WAIT; load_misaligned pulses for one cycle in the next cycle; no writeback.
REQ-023 WAIT: drive mem_addr from the latched ea and mem_byte_en; stall_pc=1; counter increments each cycle without mem_ready.
REQ-024 mem_byte_en patterns: LB/LBU use the one-hot lane of ea[1:0]; LH/LHU use 0011 or 1100 by ea[1]; LW uses 1111.
REQ-025 WAIT with mem_ready=1: register the aligned and extended data, go to DONE; response latency is 1 cycle after the mem_ready sample.
REQ-026 WAIT, counter reaching LOAD_TIMEOUT (15) without mem_ready: go to IDLE, pulse load_fault for one cycle, no writeback.
REQ-027 If mem_ready arrives in the same cycle as the timeout, mem_ready SHALL win.
REQ-028 DONE (exactly one cycle): rd_write_en=1 unless rd_write_addr=0; stall_pc=0; ignore_curr_inst=1; return to IDLE.
REQ-029 Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
REQ-030 A load_control arriving while in WAIT or DONE SHALL be ignored; the latched request governs.
REQ-031 Outside WAIT: mem_addr=0, mem_byte_en=0, mem_rw_mode=1.

Reset
REQ-032 Asserting i_rst SHALL immediately force IDLE, counter=0, and every output to 0 except mem_rw_mode=1.
REQ-033 A reset during WAIT SHALL abandon the request; no writeback or fault pulse follows.

Structure
REQ-034 The package processor_defines SHALL hold the load_control encodings, the FSM state enum and LOAD_TIMEOUT.
REQ-035 Byte/halfword extraction and extension SHALL live in a combinational sub-module load_align (inputs: word, ea[1:0], control; output: 32-bit value).

Verification
REQ-036 LB with rs1=0x1000, imm=3, mem word 0x80FF_0000, mem_ready 2 cycles later -> mem_addr=0x1000, mem_byte_en=1000, rd_write_data=0xFFFF_FF80, stall_pc high for 4 cycles.
REQ-037 LHU at ea=0x2002, word 0x9ABC_1234, mem_ready 1 cycle after entering WAIT -> mem_byte_en=1100, rd_write_data=0x0000_9ABC.
REQ-038 LW at ea=0x3001 -> load_misaligned pulses once; no memory read; rd_write_en stays 0.
REQ-039 LW at 0x4000, mem_ready never asserted -> load_fault pulses after 15 WAIT cycles; FSM returns to IDLE.
REQ-040 LW in flight and i_rst asserted mid-WAIT -> all outputs reset asynchronously; no writeback after reset release.
REQ-041 LW with rd_addr=0 and mem_ready after 1 cycle -> DONE occurs, rd_write_en=0, ignore_curr_inst=1 for one cycle.
